// File: rtl/pair_stage_pipe.sv
// pair_stage_pipe
//   Elastic pipeline of DEPTH registered node stages. Each stage carries a
//   word of 2*NPAIRS lanes and applies its own 2-bit mode to every lane
//   pair (PASS, SWAP, BUTTERFLY, ZERO) as the word is loaded into it.
//   Stage modes can only be rewritten while the pipe is empty and no word
//   is being offered, so every word in flight sees a fixed mode per stage.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_data/in_valid       upstream word and its valid flag
//   in_ready               pipe accepts the offered word this cycle
//   out_data/out_valid     result word from the last stage and its valid flag
//   out_ready              consumer accepts the result this cycle
//   cfg_we/cfg_addr/cfg_mode  stage mode write port
//   cfg_err                one-cycle pulse for a rejected mode write
//   occ                    number of valid words held in the pipe
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid high keeps its data stable until
// ready is seen; ready never depends on the data being offered.
module pair_stage_pipe #(
    parameter int WIDTH  = 8,
    parameter int NPAIRS = 6,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*NPAIRS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [2*NPAIRS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_addr,
    input  logic [1:0]                cfg_mode,
    output logic                      cfg_err,
    output logic [4:0]                occ
);

    localparam int DW = 2*NPAIRS*WIDTH;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_SWAP = 2'd1;
    localparam logic [1:0] MODE_BFLY = 2'd2;

    // Per-stage state
    logic [DW-1:0]    data_q   [DEPTH];
    logic [DW-1:0]    data_d   [DEPTH];
    logic [1:0]       mode_q   [DEPTH];
    logic [1:0]       mode_d   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Upstream view of each stage and its load enable
    logic [DW-1:0]    up_data  [DEPTH];
    logic [DEPTH-1:0] up_valid;
    logic [DEPTH-1:0] load;

    logic [4:0] occ_q;
    logic [4:0] occ_d;
    logic       cfg_err_q;
    logic       cfg_err_d;
    logic       in_hs;
    logic       out_hs;
    logic       cfg_ok;

    // Apply one stage mode to every lane pair; sums and differences wrap.
    function automatic logic [DW-1:0] apply_mode(input logic [1:0]    mode,
                                                  input logic [DW-1:0] d);
        logic [DW-1:0]    r;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        r = '0;
        for (int p = 0; p < NPAIRS; p++) begin
            a = d[2*p*WIDTH +: WIDTH];
            b = d[(2*p+1)*WIDTH +: WIDTH];
            case (mode)
                MODE_PASS: begin
                    r[2*p*WIDTH +: WIDTH]     = a;
                    r[(2*p+1)*WIDTH +: WIDTH] = b;
                end
                MODE_SWAP: begin
                    r[2*p*WIDTH +: WIDTH]     = b;
                    r[(2*p+1)*WIDTH +: WIDTH] = a;
                end
                MODE_BFLY: begin
                    r[2*p*WIDTH +: WIDTH]     = a + b;
                    r[(2*p+1)*WIDTH +: WIDTH] = a - b;
                end
                default: begin
                    r[2*p*WIDTH +: WIDTH]     = '0;
                    r[(2*p+1)*WIDTH +: WIDTH] = '0;
                end
            endcase
        end
        return r;
    endfunction

    // Ready chain, walked from the output back to the input: a stage can
    // load when it is empty or when its current word leaves this cycle.
    always_comb begin
        logic rdy;
        rdy = out_ready;
        load = '0;
        for (int s = DEPTH-1; s >= 0; s--) begin
            rdy     = ~valid_q[s] | rdy;
            load[s] = rdy;
        end
    end

    always_comb begin
        up_data[0]  = in_data;
        up_valid[0] = in_valid;
        for (int s = 1; s < DEPTH; s++) begin
            up_data[s]  = data_q[s-1];
            up_valid[s] = valid_q[s-1];
        end
    end

    assign in_ready = load[0] & ~rst;
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = valid_q[DEPTH-1] & out_ready;

    // Stage advance: data is only rewritten when a real word arrives, so a
    // stalled stage keeps its contents untouched.
    always_comb begin
        valid_d = valid_q;
        for (int s = 0; s < DEPTH; s++) begin
            data_d[s] = data_q[s];
            if (load[s]) begin
                valid_d[s] = up_valid[s];
                if (up_valid[s]) begin
                    data_d[s] = apply_mode(mode_q[s], up_data[s]);
                end
            end
        end
    end

    // Mode writes are only safe with nothing in flight and nothing arriving.
    assign cfg_ok = cfg_we & (occ_q == 5'd0) & ~in_valid &
                    ({1'b0, cfg_addr} < 5'(DEPTH));

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            mode_d[s] = mode_q[s];
            if (cfg_ok && (cfg_addr == 4'(s))) begin
                mode_d[s] = cfg_mode;
            end
        end
        cfg_err_d = cfg_we & ~cfg_ok;
    end

    always_comb begin
        occ_d = occ_q;
        case ({in_hs, out_hs})
            2'b10:   occ_d = occ_q + 5'd1;
            2'b01:   occ_d = occ_q - 5'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            occ_q     <= '0;
            cfg_err_q <= 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
                mode_q[s] <= MODE_PASS;
            end
        end else begin
            valid_q   <= valid_d;
            occ_q     <= occ_d;
            cfg_err_q <= cfg_err_d;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= data_d[s];
                mode_q[s] <= mode_d[s];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign cfg_err   = cfg_err_q;
    assign occ       = occ_q;

endmodule

// File: tb/tb_pair_stage_pipe.sv
// Bench for pair_stage_pipe: directed scenarios plus a randomized stream.
// A reference model computes each expected result from the stage modes
// with plain integer lane arithmetic; a monitor pops and compares results.
module tb_pair_stage_pipe;

    localparam int WIDTH  = 8;
    localparam int NPAIRS = 6;
    localparam int DEPTH  = 4;
    localparam int NL     = 2*NPAIRS;
    localparam int DW     = NL*WIDTH;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [1:0]    cfg_mode;
    logic          cfg_err;
    logic [4:0]    occ;

    int            n_checks;
    int            n_err;
    int            tb_occ;
    int            m_mode [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_out;
    bit            stream_done;

    pair_stage_pipe #(.WIDTH(WIDTH), .NPAIRS(NPAIRS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .occ       (occ)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w);
        int            lane [NL];
        int            a;
        int            b;
        int            m;
        logic [DW-1:0] r;
        m = 1 << WIDTH;
        for (int k = 0; k < NL; k++) lane[k] = int'(w[k*WIDTH +: WIDTH]);
        for (int s = 0; s < DEPTH; s++) begin
            for (int p = 0; p < NPAIRS; p++) begin
                a = lane[2*p];
                b = lane[2*p+1];
                case (m_mode[s])
                    1: begin lane[2*p] = b;           lane[2*p+1] = a;               end
                    2: begin lane[2*p] = (a + b) % m; lane[2*p+1] = (a - b + m) % m; end
                    3: begin lane[2*p] = 0;           lane[2*p+1] = 0;               end
                    default: ;
                endcase
            end
        end
        r = '0;
        for (int k = 0; k < NL; k++) r[k*WIDTH +: WIDTH] = WIDTH'(lane[k]);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < NL; k++) w[k*WIDTH +: WIDTH] = WIDTH'($urandom());
        return w;
    endfunction

    // ---------------- driver tasks (enter/leave 1 time unit after posedge) ----------------
    task automatic send_word(input logic [DW-1:0] w);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!done && n < 300) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_word(w));
                tb_occ++;
                done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        check_int("send_accept", int'(done), 1);
    endtask

    task automatic cfg_write(input int addr, input int mode);
        bit acc;
        acc = (tb_occ == 0) && (in_valid == 1'b0) && (addr < DEPTH);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_mode = 2'(mode);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        check_int("cfg_err_pulse", int'(cfg_err), acc ? 0 : 1);
        if (acc) m_mode[addr] = mode;
        @(posedge clk); #1;
        @(negedge clk);
        check_int("cfg_err_clear", int'(cfg_err), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_int("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h with nothing expected", out_data);
                end else begin
                    check_word("out_data", out_data, exp_q.pop_front());
                end
                last_out = out_data;
                tb_occ--;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] words [6];
        int            idx;
        int            lat;
        int            seen;

        n_checks = 0;
        n_err    = 0;
        tb_occ   = 0;
        last_out = '0;
        stream_done = 0;
        for (int s = 0; s < DEPTH; s++) m_mode[s] = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_int("rst_in_ready", int'(in_ready), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_occ", int'(occ), 0);
        check_int("rst_cfg_err", int'(cfg_err), 0);
        check_word("rst_out_data", out_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // All PASS, lanes 1..12, latency DEPTH
        w = '0;
        for (int k = 0; k < NL; k++) w[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        send_word(w);
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
            @(posedge clk); #1;
        end
        check_int("latency", lat, DEPTH);
        wait_drain();
        check_word("pass_data", last_out, w);

        // Stage 0 SWAP, stage 2 BUTTERFLY: (F0,20) -> (10,30)
        cfg_write(0, 1);
        cfg_write(2, 2);
        w = rand_word();
        w[7:0]  = 8'hF0;
        w[15:8] = 8'h20;
        send_word(w);
        in_valid = 1'b0;
        wait_drain();
        check_int("bfly_o1", int'(last_out[7:0]), 'h10);
        check_int("bfly_o2", int'(last_out[15:8]), 'h30);
        cfg_write(0, 0);
        cfg_write(2, 0);

        // Backpressure: 6 offered with out_ready low, only DEPTH accepted
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) words[i] = rand_word();
        idx = 0;
        in_valid = 1'b1;
        in_data  = words[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_word(words[idx]));
                tb_occ++;
                idx++;
            end
            @(posedge clk); #1;
            in_data = words[idx];
        end
        in_valid = 1'b0;
        check_int("full_accepted", idx, DEPTH);
        @(negedge clk);
        check_int("full_occ", int'(occ), DEPTH);
        check_int("full_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check_int("drain_one_per_cycle", seen, DEPTH);
        check_int("drain_occ_model", tb_occ, 0);

        // Rejected cfg write while busy, then bad address while idle
        out_ready = 1'b0;
        send_word(rand_word());
        send_word(rand_word());
        in_valid = 1'b0;
        @(negedge clk);
        check_int("busy_occ", int'(occ), 2);
        @(posedge clk); #1;
        cfg_write(0, 3);
        out_ready = 1'b1;
        wait_drain();
        cfg_write(5, 1);
        cfg_write(1, 1);
        send_word(rand_word());
        in_valid = 1'b0;
        wait_drain();

        // Reset mid-stream with 3 words in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(rand_word());
        in_valid = 1'b0;
        @(negedge clk);
        check_int("pre_rst_occ", int'(occ), 3);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        tb_occ = 0;
        for (int s = 0; s < DEPTH; s++) m_mode[s] = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("mid_rst_occ", int'(occ), 0);
        check_int("mid_rst_out_valid", int'(out_valid), 0);
        check_int("mid_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check_int("mid_rst_no_output", seen, 0);
        w = rand_word();
        send_word(w);
        in_valid = 1'b0;
        wait_drain();
        check_word("post_rst_pass", last_out, w);

        // Random modes and a 100-word stream with random out_ready stalls
        for (int s = 0; s < DEPTH; s++) cfg_write(s, $urandom_range(0, 3));
        fork
            begin
                for (int i = 0; i < 100; i++) send_word(rand_word());
                in_valid = 1'b0;
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        @(negedge clk);
        check_int("final_occ", int'(occ), 0);
        check_int("final_occ_model", tb_occ, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
